// File: rtl/led_sequence_checker.sv
// Walking-one LED bus monitor: locks onto a left-rotating one-hot, flywheels through misses.
// Optional sticky error flag built when LED_CHK_STICKY_EN is defined.
module led_sequence_checker #(
  parameter int unsigned MAX_LENGTH = 8,
  parameter int unsigned ERR_CNT_W  = 8,
  parameter int unsigned LOCK_LOSS  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [MAX_LENGTH-1:0]         led_in,
  output logic                          locked,
  output logic                          err,
  output logic [ERR_CNT_W-1:0]          err_count,
  output logic [$clog2(MAX_LENGTH)-1:0] position,
  output logic                          wrap,
  output logic                          err_sticky
);

  localparam int unsigned PosW = $clog2(MAX_LENGTH);
  localparam logic [MAX_LENGTH-1:0] One = {{(MAX_LENGTH-1){1'b0}}, 1'b1};
  localparam logic [3:0] LossCnt = 4'(LOCK_LOSS);

  typedef enum logic {StSearch, StTrack} state_e;

  state_e                state_q;
  logic [MAX_LENGTH-1:0] prev_q;
  logic [3:0]            miss_q;

  logic [MAX_LENGTH-1:0] expected;
  logic                  is_onehot;
  logic                  match;
  logic [3:0]            miss_inc;
  logic                  err_set;

  function automatic logic [PosW-1:0] encode(input logic [MAX_LENGTH-1:0] v);
    logic [PosW-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_LENGTH); i++) begin
      if (v[i]) idx = PosW'(i);
    end
    return idx;
  endfunction

  always_comb begin
    expected  = {prev_q[MAX_LENGTH-2:0], prev_q[MAX_LENGTH-1]};
    is_onehot = (led_in != '0) && ((led_in & (led_in - One)) == '0);
    match     = (led_in == expected);
    miss_inc  = miss_q + 4'd1;
    err_set   = (state_q == StTrack) && en && !match;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StSearch;
      prev_q    <= '0;
      miss_q    <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      wrap      <= 1'b0;
      err_count <= '0;
      position  <= '0;
    end else begin
      err  <= 1'b0;
      wrap <= 1'b0;
      case (state_q)
        StSearch: begin
          if (en && is_onehot) begin
            state_q  <= StTrack;
            prev_q   <= led_in;
            miss_q   <= '0;
            locked   <= 1'b1;
            position <= encode(led_in);
          end
        end
        StTrack: begin
          if (en) begin
            // Flywheel: advance on every sample, matched or not.
            prev_q   <= expected;
            position <= encode(expected);
            if (match) begin
              miss_q <= '0;
              wrap   <= expected[0];
            end else begin
              err <= 1'b1;
              if (err_count != '1) err_count <= err_count + 1'b1;
              if (miss_inc == LossCnt) begin
                state_q  <= StSearch;
                miss_q   <= '0;
                locked   <= 1'b0;
                position <= '0;
              end else begin
                miss_q <= miss_inc;
              end
            end
          end
        end
        default: state_q <= StSearch;
      endcase
    end
  end

`ifdef LED_CHK_STICKY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sticky <= 1'b0;
    end else if (err_set) begin
      err_sticky <= 1'b1;
    end
  end
`else
  assign err_sticky = 1'b0;
  logic unused_err_set;
  assign unused_err_set = err_set;
`endif

endmodule

// File: tb/tb_led_sequence_checker.sv
// Directed bench for led_sequence_checker: lock, wrap, glitch, lock loss, reset, saturation.
module tb_led_sequence_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] led_in;
  logic       locked, err, wrap, err_sticky;
  logic [7:0] err_count;
  logic [2:0] position;

  logic       en2;
  logic [7:0] led2;
  logic       locked2, err2, wrap2, sticky2;
  logic [1:0] count2;
  logic [2:0] pos2;

  int checks;
  int failures;

  led_sequence_checker #(.MAX_LENGTH(8), .ERR_CNT_W(8), .LOCK_LOSS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .led_in(led_in), .locked(locked), .err(err),
    .err_count(err_count), .position(position), .wrap(wrap), .err_sticky(err_sticky)
  );

  led_sequence_checker #(.MAX_LENGTH(8), .ERR_CNT_W(2), .LOCK_LOSS(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en2), .led_in(led2), .locked(locked2), .err(err2),
    .err_count(count2), .position(pos2), .wrap(wrap2), .err_sticky(sticky2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    en = 1'b1;
    led_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic [7:0] v);
    @(negedge clk);
    en2 = 1'b1;
    led2 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    en2 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic exp_sticky;

  initial begin
    checks = 0;
    failures = 0;
`ifdef LED_CHK_STICKY_EN
    exp_sticky = 1'b1;
`else
    exp_sticky = 1'b0;
`endif
    rst = 1'b0;
    en = 1'b0;
    led_in = '0;
    en2 = 1'b0;
    led2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_locked", locked, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_count", err_count, 0);
    check_eq("rst_pos", position, 0);
    check_eq("rst_wrap", wrap, 0);
    check_eq("rst_sticky", err_sticky, 0);
    @(negedge clk);
    rst = 1'b1;

    // Clean walk 0x01..0x80 then 0x01.
    for (int i = 0; i < 8; i++) begin
      drive(8'h01 << i);
      check_eq("walk_locked", locked, 1);
      check_eq("walk_pos", position, i);
      check_eq("walk_wrap", wrap, 0);
      check_eq("walk_err", err, 0);
    end
    drive(8'h01);
    check_eq("wrap_pulse", wrap, 1);
    check_eq("wrap_pos", position, 0);
    check_eq("walk_count", err_count, 0);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check_eq("hold_wrap", wrap, 0);
    check_eq("hold_pos", position, 0);
    check_eq("hold_locked", locked, 1);

    // Glitch at 0x04; flywheel expects 0x10 next.
    drive(8'h02);
    drive(8'h04);
    check_eq("pre_glitch_pos", position, 2);
    drive(8'h04);
    check_eq("glitch_err", err, 1);
    check_eq("glitch_count", err_count, 1);
    check_eq("glitch_locked", locked, 1);
    check_eq("glitch_wrap", wrap, 0);
    check_eq("glitch_sticky", err_sticky, exp_sticky);
    drive(8'h10);
    check_eq("recover_err", err, 0);
    check_eq("recover_locked", locked, 1);
    check_eq("recover_pos", position, 4);
    check_eq("recover_count", err_count, 1);

    // Lock loss after two misses, then re-lock.
    do_reset();
    check_eq("rst2_count", err_count, 0);
    drive(8'h01);
    drive(8'h02);
    drive(8'h04);
    drive(8'h08);
    drive(8'h00);
    check_eq("loss1_err", err, 1);
    check_eq("loss1_locked", locked, 1);
    check_eq("loss1_count", err_count, 1);
    drive(8'h03);
    check_eq("loss2_err", err, 1);
    check_eq("loss2_locked", locked, 0);
    check_eq("loss2_count", err_count, 2);
    check_eq("loss2_pos", position, 0);
    drive(8'h40);
    check_eq("relock_locked", locked, 1);
    check_eq("relock_pos", position, 6);
    check_eq("relock_err", err, 0);

    // Async reset mid-TRACK with err_count = 3.
    drive(8'h40);
    check_eq("pre_rst_count", err_count, 3);
    check_eq("pre_rst_locked", locked, 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_locked", locked, 0);
    check_eq("async_count", err_count, 0);
    check_eq("async_pos", position, 0);
    check_eq("async_err", err, 0);
    check_eq("async_wrap", wrap, 0);
    check_eq("async_sticky", err_sticky, 0);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    drive(8'h20);
    check_eq("post_rst_locked", locked, 1);
    check_eq("post_rst_pos", position, 5);

    // Non one-hot samples in SEARCH.
    do_reset();
    drive(8'h00);
    check_eq("srch00_locked", locked, 0);
    check_eq("srch00_err", err, 0);
    drive(8'h05);
    check_eq("srch05_locked", locked, 0);
    check_eq("srch05_err", err, 0);
    drive(8'hFF);
    check_eq("srchff_locked", locked, 0);
    check_eq("srchff_err", err, 0);
    check_eq("srch_count", err_count, 0);

    // Saturation on the 2-bit counter instance.
    do_reset();
    drive2(8'h01);
    drive2(8'h00);
    check_eq("sat1", count2, 1);
    drive2(8'h00);
    check_eq("sat2", count2, 2);
    check_eq("sat2_locked", locked2, 0);
    drive2(8'h01);
    drive2(8'h00);
    check_eq("sat3", count2, 3);
    drive2(8'h00);
    check_eq("sat4", count2, 3);
    check_eq("sat4_err", err2, 1);
    drive2(8'h01);
    drive2(8'h00);
    check_eq("sat5", count2, 3);
    check_eq("sat5_err", err2, 1);
    check_eq("sat_sticky", sticky2, exp_sticky);
    @(negedge clk);
    en2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
